csr_access_arbiter: RTL and testbench

- Sequences all read-modify-write traffic into the single read/write port of the CSR file.
- Requester A is the pipeline CSR instruction path: CSRRW/RS/RC and their immediate forms, already decoded, with the operand selected.
- Requester F is the FPU completion path. It delivers exception flags that must be OR-accumulated into fflags and must never be lost.
- The block arbitrates between A and F, enforces fflags ordering, bounds F starvation, and issues a read cycle followed by a write cycle per operation.

---
 rtl/csr_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_csr_access_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_arbiter.sv
// CSR access arbiter: serialises pipeline CSR read-modify-writes (A) and FPU
// exception-flag merges (F) onto the single CSR file port. Every operation is
// a read cycle followed by a write cycle, so one completes every 3 cycles.
module csr_access_arbiter #(
  parameter logic [11:0] FFLAGS_ADDR  = 12'h001,
  parameter logic [11:0] FCSR_ADDR    = 12'h003,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [1:0]  a_op_i,
  input  logic [11:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  input  logic        a_wr_suppress_i,
  output logic        a_resp_valid_o,
  output logic [31:0] a_rdata_o,
  input  logic        f_valid_i,
  input  logic [4:0]  f_flags_i,
  output logic [11:0] csr_rd_addr_o,
  input  logic [31:0] csr_rd_data_i,
  output logic        csr_wr_en_o,
  output logic [11:0] csr_wr_addr_o,
  output logic [31:0] csr_wr_data_o,
  output logic        flags_pending_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {StIdle, StARd, StAWr, StFRd, StFWr} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [4:0]  pend_q;
  logic [4:0]  snap_q;
  logic [3:0]  starve_q;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic        sup_q;
  logic [31:0] old_q;
  logic [4:0]  f_in;
  logic        flush_req;
  logic        f_grant;
  logic        a_grant;

  // Grant decision uses only registered pend, so f_* never reaches csr_* outputs.
  always_comb begin
    f_in      = f_valid_i ? f_flags_i : 5'd0;
    flush_req = (pend_q != 5'd0) &&
                (!a_valid_i || (starve_q == StarveMax) ||
                 (a_addr_i == FFLAGS_ADDR) || (a_addr_i == FCSR_ADDR));
    f_grant   = (state_q == StIdle) && flush_req;
    a_grant   = (state_q == StIdle) && a_valid_i && !flush_req;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state and port outputs; everything is forced low during reset.
  always_comb begin
    state_d        = state_q;
    a_ready_o      = 1'b0;
    a_resp_valid_o = 1'b0;
    a_rdata_o      = '0;
    csr_rd_addr_o  = '0;
    csr_wr_en_o    = 1'b0;
    csr_wr_addr_o  = '0;
    csr_wr_data_o  = '0;
    unique case (state_q)
      StIdle: begin
        if (f_grant) begin
          state_d = StFRd;
        end else if (a_grant) begin
          state_d   = StARd;
          a_ready_o = 1'b1;
        end
      end
      StARd: begin
        csr_rd_addr_o = addr_q;
        state_d       = StAWr;
      end
      StAWr: begin
        a_resp_valid_o = 1'b1;
        a_rdata_o      = old_q;
        csr_wr_en_o    = (op_q != 2'b00) && !sup_q;
        csr_wr_addr_o  = addr_q;
        unique case (op_q)
          2'b01:   csr_wr_data_o = wdata_q;
          2'b10:   csr_wr_data_o = old_q | wdata_q;
          2'b11:   csr_wr_data_o = old_q & ~wdata_q;
          default: csr_wr_data_o = old_q;
        endcase
        state_d = StIdle;
      end
      StFRd: begin
        csr_rd_addr_o = FFLAGS_ADDR;
        state_d       = StFWr;
      end
      StFWr: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = FFLAGS_ADDR;
        csr_wr_data_o = {old_q[31:5], old_q[4:0] | snap_q};
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d        = StIdle;
      a_ready_o      = 1'b0;
      a_resp_valid_o = 1'b0;
      a_rdata_o      = '0;
      csr_rd_addr_o  = '0;
      csr_wr_en_o    = 1'b0;
      csr_wr_addr_o  = '0;
      csr_wr_data_o  = '0;
    end
  end

  // Datapath: pending flags, snapshot, captured A request, read data, starvation count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      snap_q   <= '0;
      starve_q <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sup_q    <= 1'b0;
      old_q    <= '0;
    end else begin
      // Flags arriving during the snapshot cycle stay pending for the next flush.
      if (state_q == StFRd) begin
        snap_q <= pend_q;
        pend_q <= f_in;
        old_q  <= csr_rd_data_i;
      end else begin
        pend_q <= pend_q | f_in;
      end
      if (state_q == StARd) old_q <= csr_rd_data_i;
      if (a_grant) begin
        op_q    <= a_op_i;
        addr_q  <= a_addr_i;
        wdata_q <= a_wdata_i;
        sup_q   <= a_wr_suppress_i;
      end
      if (pend_q == 5'd0)                              starve_q <= '0;
      else if (f_grant)                                starve_q <= '0;
      else if (a_grant && (starve_q != StarveMax))     starve_q <= starve_q + 4'd1;
    end
  end

  assign flags_pending_o = !rst && (pend_q != 5'd0);
  assign busy_o          = !rst && (state_q != StIdle);

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: directed scenarios followed by random traffic,
// all checked against an operation-level model of arbitration and CSR contents.
module tb_csr_access_arbiter;

  localparam int unsigned Limit      = 2;
  localparam logic [11:0] FflagsAddr = 12'h001;
  localparam logic [11:0] FcsrAddr   = 12'h003;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid_i, a_ready_o, a_wr_suppress_i, a_resp_valid_o;
  logic [1:0]  a_op_i;
  logic [11:0] a_addr_i;
  logic [31:0] a_wdata_i, a_rdata_o;
  logic        f_valid_i;
  logic [4:0]  f_flags_i;
  logic [11:0] csr_rd_addr_o, csr_wr_addr_o;
  logic [31:0] csr_rd_data_i, csr_wr_data_o;
  logic        csr_wr_en_o, flags_pending_o, busy_o;

  logic [31:0] csr_mem [4096];
  logic [31:0] gold    [4096];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: phase counts remaining cycles of the current operation (0 = free to grant).
  int          m_phase = 0;
  int          m_starve = 0;
  logic [4:0]  m_pend = '0;
  logic [4:0]  m_snap;
  bit          m_is_f;
  logic [1:0]  m_op;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_sup;
  bit          m_last_ready;
  logic [31:0] m_last_rdata;
  byte         grants[$];

  csr_access_arbiter #(
    .FFLAGS_ADDR (FflagsAddr),
    .FCSR_ADDR   (FcsrAddr),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid_i      (a_valid_i),
    .a_ready_o      (a_ready_o),
    .a_op_i         (a_op_i),
    .a_addr_i       (a_addr_i),
    .a_wdata_i      (a_wdata_i),
    .a_wr_suppress_i(a_wr_suppress_i),
    .a_resp_valid_o (a_resp_valid_o),
    .a_rdata_o      (a_rdata_o),
    .f_valid_i      (f_valid_i),
    .f_flags_i      (f_flags_i),
    .csr_rd_addr_o  (csr_rd_addr_o),
    .csr_rd_data_i  (csr_rd_data_i),
    .csr_wr_en_o    (csr_wr_en_o),
    .csr_wr_addr_o  (csr_wr_addr_o),
    .csr_wr_data_o  (csr_wr_data_o),
    .flags_pending_o(flags_pending_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file: combinational read, clocked write.
  assign csr_rd_data_i = csr_mem[csr_rd_addr_o];
  always @(posedge clk) if (csr_wr_en_o) csr_mem[csr_wr_addr_o] <= csr_wr_data_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, a_ready_o, 32'd0);
    check({tag, "_resp"}, a_resp_valid_o, 32'd0);
    check({tag, "_rdata"}, a_rdata_o, 32'd0);
    check({tag, "_rd_addr"}, csr_rd_addr_o, 32'd0);
    check({tag, "_wr_en"}, csr_wr_en_o, 32'd0);
    check({tag, "_wr_addr"}, csr_wr_addr_o, 32'd0);
    check({tag, "_wr_data"}, csr_wr_data_o, 32'd0);
    check({tag, "_pending"}, flags_pending_o, 32'd0);
    check({tag, "_busy"}, busy_o, 32'd0);
  endtask

  // One clock cycle: inputs already driven; compare against the model, then advance.
  task automatic step();
    logic [4:0]  fin;
    logic        e_ready, e_wen, e_resp;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata, e_rdata, old;
    bit          took;
    #1;
    fin = f_valid_i ? f_flags_i : 5'd0;
    e_ready = 0; e_wen = 0; e_resp = 0; e_waddr = '0; e_wdata = '0; e_rdata = '0;
    took = 0;
    check("busy", busy_o, {31'd0, m_phase != 0});
    if (m_pend == 5'd0) m_starve = 0;
    if (m_phase == 0) begin
      check("flags_pending", flags_pending_o, {31'd0, m_pend != 5'd0});
      check("rd_addr_idle", csr_rd_addr_o, 32'd0);
      if (m_pend != 5'd0 && (!a_valid_i || m_starve == Limit ||
                             a_addr_i == FflagsAddr || a_addr_i == FcsrAddr)) begin
        // Flush takes every flag seen up to and including this cycle.
        m_is_f = 1; m_snap = m_pend | fin; m_pend = '0; took = 1;
        m_starve = 0; m_phase = 2; grants.push_back(8'h46);
      end else if (a_valid_i) begin
        e_ready = 1; m_is_f = 0; m_op = a_op_i; m_addr = a_addr_i;
        m_wdata = a_wdata_i; m_sup = a_wr_suppress_i;
        if (m_pend != 5'd0 && m_starve < Limit) m_starve++;
        m_phase = 2; grants.push_back(8'h41);
      end
    end else if (m_phase == 2) begin
      check("rd_addr", csr_rd_addr_o, {20'd0, m_is_f ? FflagsAddr : m_addr});
      m_phase = 1;
    end else begin
      if (m_is_f) begin
        old = gold[FflagsAddr];
        e_wen = 1; e_waddr = FflagsAddr; e_wdata = {old[31:5], old[4:0] | m_snap};
      end else begin
        old = gold[m_addr];
        e_resp = 1; e_rdata = old; e_waddr = m_addr;
        e_wen = (m_op != 2'b00) && !m_sup;
        case (m_op)
          2'b01:   e_wdata = m_wdata;
          2'b10:   e_wdata = old | m_wdata;
          default: e_wdata = old & ~m_wdata;
        endcase
        m_last_rdata = old;
      end
      if (e_wen) gold[e_waddr] = e_wdata;
      m_phase = 0;
    end
    check("a_ready", a_ready_o, {31'd0, e_ready});
    check("resp_valid", a_resp_valid_o, {31'd0, e_resp});
    check("wr_en", csr_wr_en_o, {31'd0, e_wen});
    if (e_resp) check("rdata", a_rdata_o, e_rdata);
    if (e_wen) begin
      check("wr_addr", csr_wr_addr_o, {20'd0, e_waddr});
      check("wr_data", csr_wr_data_o, e_wdata);
    end
    if (!took) m_pend = m_pend | fin;
    m_last_ready = e_ready;
    @(posedge clk);
    #1;
  endtask

  // Hold an A request until accepted, then let it complete.
  task automatic run_a(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic sup, output int waited);
    a_valid_i = 1; a_op_i = op; a_addr_i = addr; a_wdata_i = wd; a_wr_suppress_i = sup;
    f_valid_i = 0;
    waited = 0;
    forever begin
      step();
      if (m_last_ready) break;
      waited++;
      if (waited > 20) begin
        check("a_ready_timeout", a_ready_o, 32'd1);
        break;
      end
    end
    a_valid_i = 0;
    step();
    step();
  endtask

  logic [11:0] addr_pool [5];
  int          w;
  logic [31:0] saved;

  initial begin
    addr_pool[0] = 12'h340; addr_pool[1] = 12'h300; addr_pool[2] = FflagsAddr;
    addr_pool[3] = FcsrAddr; addr_pool[4] = 12'h305;
    for (int i = 0; i < 4096; i++) csr_mem[i] = $urandom;
    csr_mem[12'h340] = 32'h12345678;
    csr_mem[12'h300] = 32'h000000F0;
    csr_mem[FflagsAddr] = 32'h00000010;
    gold = csr_mem;

    rst = 1; a_valid_i = 0; a_op_i = 0; a_addr_i = 0; a_wdata_i = 0; a_wr_suppress_i = 0;
    f_valid_i = 0; f_flags_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst = 0;
    step();

    // A-only write.
    run_a(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, w);
    check("a_write_wait", w, 32'd0);
    check("a_write_mem", csr_mem[12'h340], 32'hDEADBEEF);
    check("a_write_rdata", m_last_rdata, 32'h12345678);

    // Set with suppress leaves the CSR alone; clear then removes bits.
    run_a(2'b10, 12'h300, 32'h0000000F, 1'b1, w);
    check("set_sup_mem", csr_mem[12'h300], 32'h000000F0);
    run_a(2'b11, 12'h300, 32'h00000030, 1'b0, w);
    check("clear_mem", csr_mem[12'h300], 32'h000000C0);

    // Flag accumulation; a flag arriving during the snapshot cycle waits for the next flush.
    f_valid_i = 1; f_flags_i = 5'h01; step();
    f_valid_i = 0; step();
    f_valid_i = 1; f_flags_i = 5'h04; step();
    f_valid_i = 0; step();
    check("flush1_mem", csr_mem[FflagsAddr], 32'h00000011);
    check("flush1_pending", flags_pending_o, 32'd1);
    step(); step(); step();
    check("flush2_mem", csr_mem[FflagsAddr], 32'h00000015);

    // fflags ordering: pending flush lands before A reads fflags.
    f_valid_i = 1; f_flags_i = 5'h02; step();
    run_a(2'b00, FflagsAddr, 32'd0, 1'b0, w);
    check("order_wait", w, 32'd3);
    check("order_rdata_bit1", m_last_rdata[1], 32'd1);

    // Starvation bound: continuous A traffic with flags pending.
    grants.delete();
    f_valid_i = 1; f_flags_i = 5'h08; step();
    f_valid_i = 0;
    a_valid_i = 1; a_op_i = 2'b01; a_addr_i = 12'h340; a_wr_suppress_i = 0;
    for (int c = 0; c < 12; c++) begin
      a_wdata_i = $urandom;
      step();
    end
    a_valid_i = 0;
    while (m_phase != 0) step();
    check("starve_len", grants.size(), 32'd4);
    if (grants.size() >= 4) begin
      check("starve_g0", grants[0], 32'h41);
      check("starve_g1", grants[1], 32'h41);
      check("starve_g2", grants[2], 32'h46);
      check("starve_g3", grants[3], 32'h41);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!a_valid_i || m_last_ready) begin
        if ($urandom_range(0, 2) != 0) begin
          a_valid_i = 1; a_op_i = 2'($urandom); a_addr_i = addr_pool[$urandom_range(0, 4)];
          a_wdata_i = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 31));
          a_wr_suppress_i = ($urandom_range(0, 3) == 0);
        end else begin
          a_valid_i = 0;
        end
      end
      f_valid_i = ($urandom_range(0, 4) == 0);
      f_flags_i = 5'($urandom);
      step();
    end
    f_valid_i = 0;

    // Reset during the read cycle of an A operation.
    a_valid_i = 1; a_op_i = 2'b01; a_addr_i = 12'h340; a_wdata_i = 32'hA5A5A5A5;
    a_wr_suppress_i = 0;
    saved = csr_mem[12'h340];
    w = 0;
    forever begin
      step();
      if (m_last_ready) break;
      w++;
      if (w > 20) begin
        check("rst_test_timeout", a_ready_o, 32'd1);
        break;
      end
    end
    a_valid_i = 0;
    rst = 1;
    #1;
    check_all_zero("rst_midop");
    m_phase = 0; m_pend = '0; m_starve = 0;
    @(posedge clk); #1;
    rst = 0;
    check_all_zero("post_rst");
    step();
    step();
    step();
    check("rst_no_write", csr_mem[12'h340], saved);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
